// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM ramp sequencer and its period tracker.
package pwm_ctrl_pkg;

  localparam int PWM_WIDTH = 8;
  localparam int PWM_STEP_W = 4;
  localparam logic [7:0] PWM_RELOAD_RST = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BND,
    RAMP
  } state_t;

endpackage

// File: rtl/pwm_period_tracker.sv
// Mirror of the PWM counter: runs 0..reload and flags the last count of each period.
module pwm_period_tracker
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             res_i,
  input  logic             enable,
  input  logic [WIDTH-1:0] reload,
  output logic             period_o
);

  logic [WIDTH-1:0] cnt;
  logic             at_last;

  assign at_last  = (cnt == reload);
  assign period_o = at_last & enable;

  // Reload is only swapped on a boundary, so the wrap to 0 lines up with the new period.
  always_ff @(posedge clk) begin
    if (res_i) begin
      cnt <= '0;
    end else if (!enable || at_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Host-facing sequencer: latches a period/duty request, swaps the period on a
// boundary and then walks the duty toward the target once per period.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH,
  parameter int STEP_W = PWM_STEP_W
) (
  input  logic              clk,
  input  logic              res_i,
  input  logic              enable_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [WIDTH-1:0]  cfg_reload_i,
  input  logic [WIDTH-1:0]  cfg_duty_i,
  input  logic [STEP_W-1:0] cfg_step_i,
  output logic [WIDTH-1:0]  set_thres_o,
  output logic [WIDTH-1:0]  clr_thres_o,
  output logic [WIDTH-1:0]  reload_o,
  output logic              period_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int EXT_W = WIDTH + 1;

  state_t            state;
  state_t            next_state;
  logic [WIDTH-1:0]  cur;
  logic [WIDTH-1:0]  reload_r;
  logic [WIDTH-1:0]  tgt_reload;
  logic [WIDTH-1:0]  tgt_duty;
  logic [STEP_W-1:0] step_r;
  logic              ready_r;
  logic              done_r;
  logic              period;
  logic              accept;
  logic              apply_step;
  logic              load_reload;
  logic              finish;
  logic [WIDTH-1:0]  nxt_duty;
  logic [EXT_W-1:0]  cur_ext;
  logic [EXT_W-1:0]  tgt_ext;
  logic [EXT_W-1:0]  sum;
  logic [EXT_W-1:0]  diff;

  pwm_period_tracker #(
    .WIDTH(WIDTH)
  ) u_tracker (
    .clk      (clk),
    .res_i    (res_i),
    .enable   (enable_i),
    .reload   (reload_r),
    .period_o (period)
  );

  assign accept = enable_i & cfg_valid_i & ready_r & (state == IDLE);

  // Saturating step in one extra bit: a borrow out of cur - step shows up as the top bit.
  always_comb begin
    cur_ext  = {1'b0, cur};
    tgt_ext  = {1'b0, tgt_duty};
    sum      = cur_ext + EXT_W'(step_r);
    diff     = cur_ext - EXT_W'(step_r);
    nxt_duty = tgt_duty;
    if (step_r == '0 || tgt_duty == cur) begin
      nxt_duty = tgt_duty;
    end else if (tgt_duty > cur) begin
      nxt_duty = (sum >= tgt_ext) ? tgt_duty : sum[WIDTH-1:0];
    end else begin
      nxt_duty = (diff[WIDTH] || diff <= tgt_ext) ? tgt_duty : diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (res_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    apply_step  = 1'b0;
    load_reload = 1'b0;
    finish      = 1'b0;
    if (!enable_i) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) next_state = WAIT_BND;
        end
        WAIT_BND: begin
          if (period) begin
            apply_step  = 1'b1;
            load_reload = 1'b1;
            finish      = (nxt_duty == tgt_duty);
            next_state  = finish ? IDLE : RAMP;
          end
        end
        RAMP: begin
          if (period) begin
            apply_step = 1'b1;
            finish     = (nxt_duty == tgt_duty);
            next_state = finish ? IDLE : RAMP;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Dropping enable clears duty and the pending request but keeps the programmed period.
  always_ff @(posedge clk) begin
    if (res_i) begin
      cur        <= '0;
      reload_r   <= WIDTH'(PWM_RELOAD_RST);
      tgt_reload <= '0;
      tgt_duty   <= '0;
      step_r     <= '0;
      ready_r    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r  <= finish;
      ready_r <= enable_i && (next_state == IDLE);
      if (!enable_i) begin
        cur        <= '0;
        tgt_reload <= '0;
        tgt_duty   <= '0;
        step_r     <= '0;
      end else begin
        if (accept) begin
          tgt_reload <= cfg_reload_i;
          tgt_duty   <= cfg_duty_i;
          step_r     <= cfg_step_i;
        end
        if (apply_step) cur <= nxt_duty;
        if (load_reload) reload_r <= tgt_reload;
      end
    end
  end

  assign set_thres_o = '0;
  assign clr_thres_o = cur;
  assign reload_o    = reload_r;
  assign period_o    = period;
  assign busy_o      = (state != IDLE);
  assign cfg_ready_o = ready_r;
  assign done_o      = done_r;

endmodule
